// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared types for the regfile access controller.
//   RF_XLEN / RF_AW : default data / address widths.
//   tag_t           : owner of the regfile slot granted in a cycle.
//   tag_entry_t     : one tag-pipeline stage (slot owner plus per-port
//                     immediate return data for x0 and write bypass).
package rf_ctrl_pkg;

    localparam int RF_XLEN = 32;
    localparam int RF_AW   = 5;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_RS1  = 2'd1,
        TAG_RS2  = 2'd2,
        TAG_WR   = 2'd3
    } tag_t;

    typedef struct packed {
        tag_t               tag;
        logic               rs1_imm;
        logic               rs2_imm;
        logic [RF_XLEN-1:0] rs1_idata;
        logic [RF_XLEN-1:0] rs2_idata;
    } tag_entry_t;

endpackage

// File: rtl/rf_starve_ctr.sv
// rf_starve_ctr: saturating starvation counter for one read port.
//   clk, rst_n : clock, async active-low reset
//   inc        : port requested but lost the slot to a write this cycle
//   clr        : port granted or request dropped (wins over inc)
//   starved    : counter has reached LIM
module rf_starve_ctr #(
    parameter int LIM = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic starved
);
    localparam int CW = $clog2(LIM + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != CW'(LIM)))
            cnt <= cnt + 1'b1;
    end

    assign starved = (cnt == CW'(LIM));

endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares a single-port regfile among rs1 read, rs2 read
// and rd writeback. One regfile operation per cycle; a 3-stage tag pipeline
// matches the regfile's latency so each read returns a one-cycle rvalid
// pulse exactly 3 edges after acceptance.
//   rs1_*/rs2_* : read request/address, comb grant, rvalid pulse, rdata
//   wr_*        : write request/address/data, comb grant
//   rf_*        : registered regfile controls; rf_r_out is regfile data
// Optional: RF_WR_BYPASS_EN forwards wr_data to a same-cycle read of the
// same nonzero address instead of making the read wait.
// XLEN must equal rf_ctrl_pkg::RF_XLEN (immediate data lives in the tag
// entry struct).
module regfile_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int XLEN       = RF_XLEN,
    parameter int AW         = RF_AW,
    parameter int STARVE_LIM = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rs1_req,
    input  logic [AW-1:0]   rs1_addr,
    output logic            rs1_gnt,
    output logic            rs1_rvalid,
    output logic [XLEN-1:0] rs1_rdata,
    input  logic            rs2_req,
    input  logic [AW-1:0]   rs2_addr,
    output logic            rs2_gnt,
    output logic            rs2_rvalid,
    output logic [XLEN-1:0] rs2_rdata,
    input  logic            wr_req,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic            wr_gnt,
    output logic            rf_r_enable,
    output logic            rf_w_enable,
    output logic [AW-1:0]   rf_r_select,
    output logic [AW-1:0]   rf_w_select,
    output logic [XLEN-1:0] rf_w_val,
    input  logic [XLEN-1:0] rf_r_out
);
    logic rs1_z, rs2_z, wr_z;        // x0 accesses: no slot needed
    logic rs1_byp, rs2_byp;          // read served from same-cycle write
    logic w_need, r1_need, r2_need;  // requesters that need the slot
    logic st1, st2;
    tag_t slot;
    tag_entry_t new_ent;
    tag_entry_t [3:1] pipe;

    always_comb begin
        rs1_z  = rs1_req && (rs1_addr == '0);
        rs2_z  = rs2_req && (rs2_addr == '0);
        wr_z   = wr_req  && (wr_addr  == '0);
        w_need = wr_req  && !wr_z;
`ifdef RF_WR_BYPASS_EN
        rs1_byp = rs1_req && w_need && (rs1_addr == wr_addr);
        rs2_byp = rs2_req && w_need && (rs2_addr == wr_addr);
`else
        rs1_byp = 1'b0;
        rs2_byp = 1'b0;
`endif
        r1_need = rs1_req && !rs1_z && !rs1_byp;
        r2_need = rs2_req && !rs2_z && !rs2_byp;

        // Starved ports pre-empt the write; otherwise write > rs1 > rs2.
        slot = TAG_NONE;
        if (!rst_n)                slot = TAG_NONE;
        else if (r1_need && st1)   slot = TAG_RS1;
        else if (r2_need && st2)   slot = TAG_RS2;
        else if (w_need)           slot = TAG_WR;
        else if (r1_need)          slot = TAG_RS1;
        else if (r2_need)          slot = TAG_RS2;

        // Bypassed reads ride on the write grant; if the write loses the
        // slot to a starved port, the bypassed read waits with it.
        wr_gnt  = rst_n && (wr_z || (slot == TAG_WR));
        rs1_gnt = rst_n && (rs1_z || (slot == TAG_RS1) || (rs1_byp && slot == TAG_WR));
        rs2_gnt = rst_n && (rs2_z || (slot == TAG_RS2) || (rs2_byp && slot == TAG_WR));

        new_ent           = '0;
        new_ent.tag       = (slot == TAG_NONE && wr_gnt) ? TAG_WR : slot;
        new_ent.rs1_imm   = rs1_gnt && (rs1_z || rs1_byp);
        new_ent.rs2_imm   = rs2_gnt && (rs2_z || rs2_byp);
        new_ent.rs1_idata = rs1_byp ? RF_XLEN'(wr_data) : '0;
        new_ent.rs2_idata = rs2_byp ? RF_XLEN'(wr_data) : '0;
    end

    rf_starve_ctr #(.LIM(STARVE_LIM)) u_starve_rs1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (rs1_req && !rs1_gnt && (slot == TAG_WR)),
        .clr     (!rs1_req || rs1_gnt),
        .starved (st1)
    );

    rf_starve_ctr #(.LIM(STARVE_LIM)) u_starve_rs2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (rs2_req && !rs2_gnt && (slot == TAG_WR)),
        .clr     (!rs2_req || rs2_gnt),
        .starved (st2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_r_enable <= 1'b0;
            rf_w_enable <= 1'b0;
            rf_r_select <= '0;
            rf_w_select <= '0;
            rf_w_val    <= '0;
            pipe        <= '0;
            rs1_rvalid  <= 1'b0;
            rs2_rvalid  <= 1'b0;
            rs1_rdata   <= '0;
            rs2_rdata   <= '0;
        end else begin
            rf_r_enable <= (slot == TAG_RS1) || (slot == TAG_RS2);
            rf_w_enable <= (slot == TAG_WR);
            if (slot == TAG_RS1)      rf_r_select <= rs1_addr;
            else if (slot == TAG_RS2) rf_r_select <= rs2_addr;
            if (slot == TAG_WR) begin
                rf_w_select <= wr_addr;
                rf_w_val    <= wr_data;
            end

            pipe[1] <= new_ent;
            pipe[2] <= pipe[1];
            pipe[3] <= pipe[2];

            // Stage 3 lines up with rf_r_out for the read issued 3 edges ago.
            rs1_rvalid <= (pipe[3].tag == TAG_RS1) || pipe[3].rs1_imm;
            rs2_rvalid <= (pipe[3].tag == TAG_RS2) || pipe[3].rs2_imm;
            if (pipe[3].rs1_imm)             rs1_rdata <= XLEN'(pipe[3].rs1_idata);
            else if (pipe[3].tag == TAG_RS1) rs1_rdata <= rf_r_out;
            if (pipe[3].rs2_imm)             rs2_rdata <= XLEN'(pipe[3].rs2_idata);
            else if (pipe[3].tag == TAG_RS2) rs2_rdata <= rf_r_out;
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
module tb_regfile_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rs1_req, rs2_req, wr_req;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr;
    logic [31:0] wr_data;
    logic        rs1_gnt, rs2_gnt, wr_gnt, rs1_rvalid, rs2_rvalid;
    logic [31:0] rs1_rdata, rs2_rdata, rf_w_val, rf_r_out;
    logic        rf_r_enable, rf_w_enable;
    logic [4:0]  rf_r_select, rf_w_select;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc, acc2;
    logic both_hi = 1'b0;
    logic wz_seen = 1'b0;

    typedef struct { int cyc; logic [31:0] data; } ret_t;
    ret_t q1[$];
    ret_t q2[$];

    typedef struct {
        logic r1; logic [4:0] a1;
        logic r2; logic [4:0] a2;
        logic w;  logic [4:0] wa; logic [31:0] wd;
        logic [2:0] exp;  // {rs1_gnt, rs2_gnt, wr_gnt}
    } vec_t;
    vec_t tbl[12];

    regfile_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_req(rs1_req), .rs1_addr(rs1_addr), .rs1_gnt(rs1_gnt),
        .rs1_rvalid(rs1_rvalid), .rs1_rdata(rs1_rdata),
        .rs2_req(rs2_req), .rs2_addr(rs2_addr), .rs2_gnt(rs2_gnt),
        .rs2_rvalid(rs2_rvalid), .rs2_rdata(rs2_rdata),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rf_r_enable(rf_r_enable), .rf_w_enable(rf_w_enable),
        .rf_r_select(rf_r_select), .rf_w_select(rf_w_select),
        .rf_w_val(rf_w_val), .rf_r_out(rf_r_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Regfile model: samples controls at E1, writes array / reads at E2.
    // Not reset, so contents survive the arbiter's reset.
    logic [31:0] mem [32];
    logic        s_re, s_we;
    logic [4:0]  s_rsel, s_wsel;
    logic [31:0] s_wval;
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hBAD0_0000 + i;
        mem[1] = 32'h11; mem[2] = 32'h22; mem[4] = 32'h44;
        s_re = 0; s_we = 0; s_rsel = 0; s_wsel = 0; s_wval = 0; rf_r_out = 0;
        forever begin
            @(posedge clk);
            if (s_re) rf_r_out <= mem[s_rsel];
            if (s_we) mem[s_wsel] <= s_wval;
            s_re <= rf_r_enable; s_rsel <= rf_r_select;
            s_we <= rf_w_enable; s_wsel <= rf_w_select; s_wval <= rf_w_val;
        end
    end

    // Return monitor: logs every rvalid pulse with its cycle stamp.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rs1_rvalid) q1.push_back('{cyc, rs1_rdata});
            if (rs2_rvalid) q2.push_back('{cyc, rs2_rdata});
            if (rf_r_enable && rf_w_enable) both_hi <= 1'b1;
            if (rf_w_enable && rf_w_select == 5'd0) wz_seen <= 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r1, input logic [4:0] a1, input logic r2,
                         input logic [4:0] a2, input logic w, input logic [4:0] wa,
                         input logic [31:0] wd);
        rs1_req = r1; rs1_addr = a1; rs2_req = r2; rs2_addr = a2;
        wr_req = w; wr_addr = wa; wr_data = wd;
    endtask

    // Expects the next logged return on a port 3 edges after acceptance edge a.
    task automatic check_ret(input int port, input int a, input logic [31:0] d, input string nm);
        ret_t r;
        int n;
        int guard = 0;
        while (cyc < a + 4 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n = (port == 1) ? q1.size() : q2.size();
        chk({nm, " present"}, 32'(n > 0), 32'd1);
        if (n > 0) begin
            r = (port == 1) ? q1.pop_front() : q2.pop_front();
            chk({nm, " latency"}, 32'(r.cyc - a), 32'd3);
            chk({nm, " data"}, r.data, d);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 32'h1);
        tbl[0]  = '{0, 5'd0,  0, 5'd0,  0, 5'd0,  32'h0,  3'b000};
        tbl[1]  = '{1, 5'd1,  0, 5'd0,  0, 5'd0,  32'h0,  3'b100};
        tbl[2]  = '{0, 5'd0,  1, 5'd2,  0, 5'd0,  32'h0,  3'b010};
        tbl[3]  = '{1, 5'd1,  1, 5'd2,  0, 5'd0,  32'h0,  3'b100};
        tbl[4]  = '{1, 5'd1,  0, 5'd0,  1, 5'd20, 32'h20, 3'b001};
        tbl[5]  = '{1, 5'd0,  0, 5'd0,  1, 5'd20, 32'h20, 3'b101};
        tbl[6]  = '{1, 5'd1,  1, 5'd2,  1, 5'd0,  32'h99, 3'b101};
        tbl[7]  = '{1, 5'd0,  1, 5'd0,  0, 5'd0,  32'h0,  3'b110};
`ifdef RF_WR_BYPASS_EN
        tbl[8]  = '{1, 5'd21, 0, 5'd0,  1, 5'd21, 32'h21, 3'b101};
        tbl[9]  = '{1, 5'd3,  1, 5'd21, 1, 5'd21, 32'h21, 3'b011};
`else
        tbl[8]  = '{1, 5'd21, 0, 5'd0,  1, 5'd21, 32'h21, 3'b001};
        tbl[9]  = '{1, 5'd3,  1, 5'd21, 1, 5'd21, 32'h21, 3'b001};
`endif
        tbl[10] = '{1, 5'd0,  1, 5'd5,  0, 5'd0,  32'h0,  3'b110};
        tbl[11] = '{1, 5'd6,  1, 5'd0,  1, 5'd22, 32'h22, 3'b011};

        // Reset state with requests pending.
        repeat (2) @(negedge clk);
        #1;
        chk("rst gnts", {29'd0, rs1_gnt, rs2_gnt, wr_gnt}, 32'd0);
        chk("rst rf_en", {30'd0, rf_r_enable, rf_w_enable}, 32'd0);
        chk("rst rvalid", {30'd0, rs1_rvalid, rs2_rvalid}, 32'd0);
        chk("rst rf_w_val", rf_w_val, 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-cycle grant table; an idle cycle between rows clears counters.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].r1, tbl[i].a1, tbl[i].r2, tbl[i].a2, tbl[i].w, tbl[i].wa, tbl[i].wd);
            #1;
            chk($sformatf("tbl%0d gnt", i), {29'd0, rs1_gnt, rs2_gnt, wr_gnt}, {29'd0, tbl[i].exp});
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        q1.delete();
        q2.delete();

        // Write x5 then read it back.
        drive(0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        #1 chk("wr5 gnt", {31'd0, wr_gnt}, 32'd1);
        @(negedge clk);
        drive(1, 5'd5, 0, 0, 0, 0, 0);
        #1;
        chk("wr5 rf_w_enable", {31'd0, rf_w_enable}, 32'd1);
        chk("wr5 rf_w_select", {27'd0, rf_w_select}, 32'd5);
        chk("wr5 rf_w_val", rf_w_val, 32'hDEADBEEF);
        chk("rd5 gnt", {31'd0, rs1_gnt}, 32'd1);
        acc = cyc + 1;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_ret(1, acc, 32'hDEADBEEF, "rd5");
        chk("rd5 pulse ends", {31'd0, rs1_rvalid}, 32'd0);
        chk("rd5 rdata holds", rs1_rdata, 32'hDEADBEEF);

        // rs1/rs2 contention: rs1 first, rs2 next cycle.
        @(negedge clk);
        drive(1, 5'd1, 1, 5'd2, 0, 0, 0);
        #1 chk("dual c1 gnt", {29'd0, rs1_gnt, rs2_gnt, wr_gnt}, 32'b100);
        acc = cyc + 1;
        @(negedge clk);
        drive(0, 0, 1, 5'd2, 0, 0, 0);
        #1 chk("dual c2 gnt", {29'd0, rs1_gnt, rs2_gnt, wr_gnt}, 32'b010);
        acc2 = cyc + 1;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_ret(1, acc, 32'h11, "dual rs1");
        check_ret(2, acc2, 32'h22, "dual rs2");

        // x0 read alongside write; write to x0 dropped.
        @(negedge clk);
        drive(1, 5'd0, 0, 0, 1, 5'd3, 32'h33);
        #1 chk("x0rd+wr gnt", {29'd0, rs1_gnt, rs2_gnt, wr_gnt}, 32'b101);
        acc = cyc + 1;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_ret(1, acc, 32'h0, "x0rd");
        drive(0, 0, 0, 0, 1, 5'd0, 32'h1234);
        #1 chk("wr x0 gnt", {31'd0, wr_gnt}, 32'd1);
        @(negedge clk);
        drive(1, 5'd0, 0, 0, 0, 0, 0);
        #1;
        chk("wr x0 no rf_w_enable", {31'd0, rf_w_enable}, 32'd0);
        acc = cyc + 1;
        @(negedge clk);
        drive(1, 5'd3, 0, 0, 0, 0, 0);
        #1 acc2 = cyc + 1;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_ret(1, acc, 32'h0, "x0 after wr");
        check_ret(1, acc2, 32'h33, "rd x3");

        // Starvation: write held, rs2 wins on its 5th request cycle.
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 1, 5'd4, 1, 5'd9, 32'h99);
            #1;
            chk($sformatf("starve c%0d", i), {30'd0, rs2_gnt, wr_gnt},
                (i < 5) ? 32'b01 : 32'b10);
            if (i == 5) acc = cyc + 1;
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 1, 5'd9, 32'h99);
        #1 chk("starve wr resumes", {30'd0, rs2_gnt, wr_gnt}, 32'b01);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_ret(2, acc, 32'h44, "starve rd4");

        // Same-cycle write and read of x7.
        @(negedge clk);
        drive(1, 5'd7, 0, 0, 1, 5'd7, 32'hA5A5A5A5);
`ifdef RF_WR_BYPASS_EN
        #1 chk("byp gnt", {29'd0, rs1_gnt, rs2_gnt, wr_gnt}, 32'b101);
        acc = cyc + 1;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 chk("byp no rf_r_enable", {31'd0, rf_r_enable}, 32'd0);
`else
        #1 chk("nobyp c1 gnt", {29'd0, rs1_gnt, rs2_gnt, wr_gnt}, 32'b001);
        @(negedge clk);
        drive(1, 5'd7, 0, 0, 0, 0, 0);
        #1 chk("nobyp c2 gnt", {31'd0, rs1_gnt}, 32'd1);
        acc = cyc + 1;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
`endif
        check_ret(1, acc, 32'hA5A5A5A5, "rd x7");

        // Reset one cycle after a read acceptance discards it.
        @(negedge clk);
        drive(1, 5'd1, 0, 0, 0, 0, 0);
        #1 chk("pre-rst gnt", {31'd0, rs1_gnt}, 32'd1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1, 5'd2, 0, 0, 1, 5'd8, 32'h8);
        #1;
        chk("rst2 gnts", {29'd0, rs1_gnt, rs2_gnt, wr_gnt}, 32'd0);
        chk("rst2 rf_r_select", {27'd0, rf_r_select}, 32'd0);
        chk("rst2 rf_w_select/val", {27'd0, rf_w_select} | rf_w_val, 32'd0);
        chk("rst2 rdata", rs1_rdata | rs2_rdata, 32'd0);
        repeat (2) @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst discards read", q1.size(), 32'd0);
        drive(1, 5'd5, 0, 0, 0, 0, 0);
        #1 acc = cyc + 1;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_ret(1, acc, 32'hDEADBEEF, "post-rst rd5");

        repeat (6) @(negedge clk);
        chk("never r&w enable", {31'd0, both_hi}, 32'd0);
        chk("never rf_w_enable x0", {31'd0, wz_seen}, 32'd0);
        chk("no extra rs1 returns", q1.size(), 32'd0);
        chk("no extra rs2 returns", q2.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
